m_seq_arb: RTL and testbench

Round-robin scheduler that shares one m_seq generator (10-bit LFSR, 1023-bit period) between N requesters. It picks a requester and loads that requester's seed into the generator. It then streams the 1023 sequence bits back to that requester, tagged with valid/last flags. A run watchdog and generator-reset sequencing keep the shared generator in a known state.

---
 rtl/m_seq_arb.sv | 155 +++++++++++++++
 tb/tb_m_seq_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_seq_arb.sv
// m_seq_arb: round-robin scheduler sharing one 10-bit m-sequence generator
// between N requesters. A winner's seed is loaded into the generator, and
// the resulting 1023-bit stream is returned with valid/last flags. A RUN
// watchdog aborts a stalled generator. The generator's synchronous reset is
// released two clocks after the block leaves reset.
module m_seq_arb #(
  parameter int N       = 4,
  parameter int SEED_W  = 10,
  parameter int TIMEOUT = 1100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N*SEED_W-1:0] seed_in,
  output logic [N-1:0]        gnt,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                bit_last,
  output logic                run_err,
  output logic                mseq_rst,
  output logic                mseq_set,
  output logic [SEED_W-1:0]   mseq_seed,
  input  logic                mseq_data,
  input  logic                mseq_done
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_SAT   = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_START,
    S_ARM,
    S_RUN,
    S_GAP
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  last;
  logic [WD_W-1:0]   wd_cnt;
  logic              rel_p0;

  logic              found;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  cand;
  logic [SEED_W-1:0] win_seed;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  function automatic logic [SEED_W-1:0] fix_seed(input logic [SEED_W-1:0] s);
    return (s == '0) ? SEED_W'(1) : s;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester after the previous winner, wrapping.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = last;
    for (int k = 1; k <= N; k++) begin
      cand = PTR_W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Pick the winning requester's seed slice out of the packed seed bus.
  always_comb begin
    win_seed = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PTR_W'(i)) win_seed = seed_in[i*SEED_W +: SEED_W];
    end
  end

  // The stream bit is the generator output; last coincides with done.
  assign bit_out  = mseq_data;
  assign bit_last = bit_valid & mseq_done;

  // Scheduler FSM with generator reset sequencing and RUN watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      last      <= PTR_INIT;
      gnt       <= '0;
      mseq_set  <= 1'b0;
      mseq_seed <= '0;
      bit_valid <= 1'b0;
      run_err   <= 1'b0;
      wd_cnt    <= '0;
      rel_p0    <= 1'b1;
      mseq_rst  <= 1'b1;
    end else begin
      // reset release stage: mseq_rst drops on the second edge after rst_n
      rel_p0   <= 1'b0;
      mseq_rst <= rel_p0;
      mseq_set <= 1'b0;
      run_err  <= 1'b0;
      case (state)
        S_INIT: begin
          if (!mseq_rst) state <= S_IDLE;
        end
        S_IDLE: begin
          if (found) begin
            gnt       <= onehot(win);
            last      <= win;
            mseq_seed <= fix_seed(win_seed);
            mseq_set  <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          state <= S_ARM;
        end
        S_ARM: begin
          bit_valid <= 1'b1;
          wd_cnt    <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (wd_cnt != WD_SAT) wd_cnt <= wd_cnt + 1'b1;
          // done wins over a coincident timeout
          if (mseq_done) begin
            bit_valid <= 1'b0;
            gnt       <= '0;
            state     <= S_GAP;
          end else if (wd_cnt >= WD_LAST) begin
            bit_valid <= 1'b0;
            gnt       <= '0;
            run_err   <= 1'b1;
            mseq_rst  <= 1'b1;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_seq_arb.sv
// Bench for m_seq_arb: a behavioural 10-bit generator, directed stimulus that
// queues the expected run for each grant, and a negedge monitor that pops and
// checks every run (grant, seed, bit stream, length, abort/reset behaviour).
module tb_m_seq_arb;
  localparam int N       = 4;
  localparam int SEED_W  = 10;
  localparam int TIMEOUT = 1100;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b1;
  logic [N-1:0]        req     = '0;
  logic [N*SEED_W-1:0] seed_in = '0;
  logic [N-1:0]        gnt;
  logic                bit_out, bit_valid, bit_last, run_err, mseq_rst, mseq_set;
  logic [SEED_W-1:0]   mseq_seed;
  logic                mseq_data, mseq_done;

  always #5 clk = ~clk;

  m_seq_arb #(.N(N), .SEED_W(SEED_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_in(seed_in), .gnt(gnt),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_last(bit_last),
    .run_err(run_err), .mseq_rst(mseq_rst), .mseq_set(mseq_set),
    .mseq_seed(mseq_seed), .mseq_data(mseq_data), .mseq_done(mseq_done)
  );

  function automatic logic [9:0] lfsr_step(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  // Behavioural generator: load on set, first bit one clock later, done on bit 1023.
  logic [9:0]  g_lfsr  = '0;
  logic [10:0] g_cnt   = '0;
  logic        g_act   = 1'b0;
  logic        g_data  = 1'b0;
  logic        no_done = 1'b0;

  always @(posedge clk) begin
    if (mseq_rst) begin
      g_act <= 1'b0;
      g_cnt <= '0;
    end else if (mseq_set) begin
      g_lfsr <= mseq_seed;
      g_act  <= 1'b1;
      g_cnt  <= '0;
    end else if (g_act) begin
      if (g_cnt == 11'd1023 && !no_done) begin
        g_act <= 1'b0;
      end else begin
        g_data <= g_lfsr[9];
        g_lfsr <= lfsr_step(g_lfsr);
        if (g_cnt != 11'd1023) g_cnt <= g_cnt + 11'd1;
      end
    end
  end
  assign mseq_done = g_act && (g_cnt == 11'd1023) && !no_done;
  assign mseq_data = g_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0]      g;
    logic [SEED_W-1:0] s;
    int                nb;
    logic              err;
    int                per;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [N-1:0] g, input logic [SEED_W-1:0] s,
                      input int nb, input logic err, input int per);
    exp_t e;
    e.g = g; e.s = s; e.nb = nb; e.err = err; e.per = per;
    sb.push_back(e);
  endtask

  task automatic set_seed(input int i, input logic [SEED_W-1:0] v);
    seed_in[i*SEED_W +: SEED_W] = v;
  endtask

  // Clock edges since rst_n released, for the generator-reset release check.
  int edges = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 3) edges <= edges + 1;
  end

  // Outputs must clear as soon as rst_n falls, before any clock edge.
  always @(negedge rst_n) begin
    #1;
    chk("async_clr", {gnt, bit_valid, bit_last, run_err, mseq_set, mseq_seed, mseq_rst}, 32'd1);
  end

  // Monitor state
  exp_t       cur;
  logic       run_act  = 1'b0;
  logic       gap_pend = 1'b0;
  logic [9:0] ref_l    = '0;
  int         nbits = 0, ones = 0, berr = 0, herr = 0;
  int         cyc = 0, last_start = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {gnt, bit_valid, bit_last, run_err, mseq_set, mseq_seed, mseq_rst}, 32'd1);
      if (run_act) begin
        chk("reset_bits", nbits, cur.nb);
        chk("reset_bitstream", berr, 0);
        run_act = 1'b0;
      end
      gap_pend   = 1'b0;
      last_start = -1;
    end else begin
      cyc++;
      chk("mseq_rst", mseq_rst, ((edges < 2) || run_err) ? 32'd1 : 32'd0);
      if (gap_pend) begin
        chk("gap_clear", {gnt, bit_valid}, 0);
        gap_pend = 1'b0;
      end
      if (mseq_set) begin
        chk("start_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          chk("grant", gnt, cur.g);
          chk("seed", mseq_seed, cur.s);
          if (cur.per > 0 && last_start >= 0) chk("period", cyc - last_start, cur.per);
          last_start = cyc;
          ref_l = cur.s; nbits = 0; ones = 0; berr = 0; herr = 0;
          run_act = 1'b1;
        end
      end
      if (run_act && bit_valid) begin
        if (bit_out !== ref_l[9]) berr++;
        ref_l = lfsr_step(ref_l);
        if (gnt !== cur.g || mseq_seed !== cur.s) herr++;
        nbits++;
        if (bit_out === 1'b1) ones++;
        if (bit_last) begin
          chk("run_len", nbits, cur.nb);
          chk("bitstream", berr, 0);
          chk("held", herr, 0);
          chk("ones", ones, 512);
          run_act  = 1'b0;
          gap_pend = 1'b1;
        end
      end else if (!run_act) begin
        chk("stray_valid", bit_valid, 0);
        chk("stray_err", run_err, 0);
      end
      if (run_act && run_err) begin
        chk("abort_kind", run_err, cur.err);
        chk("abort_len", nbits, cur.nb);
        chk("abort_outs", {gnt, bit_valid}, 0);
        chk("abort_bitstream", berr, 0);
        run_act = 1'b0;
      end
      chk("last_needs_valid", bit_last & ~bit_valid, 0);
    end
  end

  task automatic wait_last(input int budget);
    int c = 0;
    do begin @(posedge clk); #1; c++; end while (!bit_last && c < budget);
    chk("wait_last", bit_last, 1);
  endtask

  task automatic wait_err(input int budget);
    int c = 0;
    do begin @(posedge clk); #1; c++; end while (!run_err && c < budget);
    chk("wait_err", run_err, 1);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int c = 0;
    int cnt = 0;
    while (cnt < n && c < budget) begin
      @(posedge clk); #1; c++;
      if (bit_valid) cnt++;
    end
    chk("wait_bits", cnt, n);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Round robin from reset: 0,1,2,3,0 back to back
    set_seed(0, 10'h001); set_seed(1, 10'h2AB); set_seed(2, 10'h3FF); set_seed(3, 10'h155);
    push(4'b0001, 10'h001, 1023, 1'b0, 0);
    push(4'b0010, 10'h2AB, 1023, 1'b0, 1027);
    push(4'b0100, 10'h3FF, 1023, 1'b0, 1027);
    push(4'b1000, 10'h155, 1023, 1'b0, 1027);
    push(4'b0001, 10'h001, 1023, 1'b0, 1027);
    req = 4'b1111;
    repeat (5) wait_last(1200);
    req = '0;
    repeat (10) @(posedge clk);

    // Single run with seed change and req drop mid-run
    set_seed(0, 10'h001);
    push(4'b0001, 10'h001, 1023, 1'b0, 0);
    req = 4'b0001;
    wait_bits(100, 1200);
    set_seed(0, 10'h155);
    req = '0;
    wait_last(1200);
    repeat (20) @(posedge clk);

    // Zero seed is promoted to 1
    set_seed(2, 10'h000);
    push(4'b0100, 10'h001, 1023, 1'b0, 0);
    req = 4'b0100;
    wait_last(1200);
    req = '0;
    repeat (10) @(posedge clk);

    // Watchdog abort, then a normal run for another requester
    no_done = 1'b1;
    set_seed(1, 10'h2AB);
    push(4'b0010, 10'h2AB, TIMEOUT, 1'b1, 0);
    req = 4'b0010;
    wait_err(1300);
    no_done = 1'b0;
    set_seed(3, 10'h155);
    push(4'b1000, 10'h155, 1023, 1'b0, 0);
    req = 4'b1000;
    wait_last(1200);
    req = '0;
    repeat (10) @(posedge clk);

    // Reset at bit 500, then the same request reruns from the start
    set_seed(0, 10'h001);
    push(4'b0001, 10'h001, 500, 1'b0, 0);
    req = 4'b0001;
    wait_bits(500, 1200);
    @(negedge clk);
    #1 rst_n = 1'b0;
    push(4'b0001, 10'h001, 1023, 1'b0, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_last(1200);
    req = '0;
    repeat (30) @(posedge clk);

    chk("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t, expected < 500000", $time);
    $fatal(1);
  end

endmodule
